// File: rtl/sgd_x_wb_pkg.sv
// Shared constants, state encoding and sizing helpers for the x-writeback DMA drain path.
package sgd_x_wb_pkg;

    localparam int ENGINE_NUM       = 8;
    localparam int WORDS_PER_ENGINE = 4;
    localparam int BITS_PER_BANK    = 64;
    localparam int FEAT_PER_ROW     = ENGINE_NUM * BITS_PER_BANK;
    localparam int WORD_W           = 512;
    localparam int ENG_W            = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
    localparam int WCNT_W           = (WORDS_PER_ENGINE > 1) ? $clog2(WORDS_PER_ENGINE) : 1;
    localparam int ROW_SHIFT        = $clog2(FEAT_PER_ROW);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_CMD   = 5'b00010,
        S_DATA  = 5'b00100,
        S_DRAIN = 5'b01000,
        S_DONE  = 5'b10000
    } wb_state_e;

    // 33-bit intermediate keeps the round-up from wrapping for huge dimensions.
    function automatic logic [31:0] calc_epoch_words(input logic [31:0] dim);
        logic [32:0] rows;
        rows = ({1'b0, dim} + 33'(FEAT_PER_ROW - 1)) >> ROW_SHIFT;
        return 32'(rows * 33'(ENGINE_NUM * WORDS_PER_ENGINE));
    endfunction

    function automatic logic [3:0] state_code(input wb_state_e s);
        logic [3:0] c;
        case (s)
            S_IDLE:  c = 4'b0001;
            S_CMD:   c = 4'b0010;
            S_DATA:  c = 4'b0100;
            S_DRAIN: c = 4'b1000;
            S_DONE:  c = 4'b1000;
            default: c = 4'b0000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sgd_x_wb_rd_pipe.sv
// Pops the currently selected engine FIFO and carries its dout through a two-stage
// pipeline (FIFO read latency + output register), tracking which engine each pop hit.
module sgd_x_wb_rd_pipe
    import sgd_x_wb_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         active_i,
    input  logic [ENG_W-1:0]             eng_sel_i,
    input  logic [ENGINE_NUM*WORD_W-1:0] rd_data_i,
    input  logic [ENGINE_NUM-1:0]        empty_i,
    input  logic                         almost_full_i,
    output logic [ENGINE_NUM-1:0]        rd_en_o,
    output logic                         pop_o,
    output logic [WORD_W-1:0]            data_o,
    output logic                         valid_o
);

    logic                  pop_s;
    logic [ENGINE_NUM-1:0] rd_en_s;
    logic [WORD_W-1:0]     sel_data_s;
    logic                  vld1_q;
    logic [ENG_W-1:0]      eng1_q;
    logic [WORD_W-1:0]     data_q;
    logic                  valid_q;

    // Pop only the engine whose turn it is; a stalled engine blocks the others.
    always_comb begin
        pop_s            = active_i & ~empty_i[eng_sel_i] & ~almost_full_i;
        rd_en_s          = '0;
        rd_en_s[eng_sel_i] = pop_s;
    end

    // Select the dout slice of the engine popped one cycle ago.
    always_comb begin
        sel_data_s = '0;
        for (int e = 0; e < ENGINE_NUM; e++) begin
            if (eng1_q == ENG_W'(e)) begin
                sel_data_s = rd_data_i[e*WORD_W +: WORD_W];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Stage 1 tracks the pop, stage 2 registers the FIFO dout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld1_q  <= 1'b0;
            eng1_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            vld1_q  <= pop_s;
            eng1_q  <= eng_sel_i;
            valid_q <= vld1_q;
            if (vld1_q) begin
                data_q <= sel_data_s;
            end
        end
    end

    assign rd_en_o = rd_en_s;
    assign pop_o   = pop_s;
    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/sgd_x_fifo_to_dma_wr.sv
// Drains the per-engine model-x FIFOs in memory-layout order into DMA write commands/data.
// Define SGD_X_EPOCH_HISTORY_EN to place each epoch at its own host offset instead of overwriting.
module sgd_x_fifo_to_dma_wr
    import sgd_x_wb_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         started,
    input  logic [63:0]                  addr_model,
    input  logic [31:0]                  dimension,
    input  logic [31:0]                  numEpochs,
    input  logic [ENGINE_NUM*WORD_W-1:0] x_to_mem_rd_data,
    input  logic [ENGINE_NUM-1:0]        x_to_mem_empty,
    output logic [ENGINE_NUM-1:0]        x_to_mem_rd_en,
    output logic                         x_data_send_back_start,
    output logic [63:0]                  x_data_send_back_addr,
    output logic [31:0]                  x_data_send_back_length,
    output logic [WORD_W-1:0]            x_data_out,
    output logic                         x_data_out_valid,
    input  logic                         x_data_out_almost_full,
    output logic                         writeback_done,
    output logic [31:0]                  state_counters
);

    wb_state_e          state_q, state_d;
    logic               started_q;
    logic               start_rise_s;
    logic               last_pop_s;
    logic               pop_s;
    logic [63:0]        cmd_addr_q;
    logic [31:0]        epoch_words_q;
    logic [31:0]        epoch_bytes_q;
    logic [31:0]        num_epochs_q;
    logic [31:0]        epoch_q;
    logic [31:0]        total_q;
    logic [ENG_W-1:0]   eng_q;
    logic [WCNT_W-1:0]  wcnt_q;
    logic               drain_q;
    logic [15:0]        words_q;
    logic [31:0]        epoch_words_s;

    assign start_rise_s  = started & ~started_q;
    assign last_pop_s    = pop_s & (total_q == (epoch_words_q - 32'd1));
    assign epoch_words_s = calc_epoch_words(dimension);

    sgd_x_wb_rd_pipe u_rd_pipe (
        .clk_i         (clk),
        .rst_i         (rst),
        .active_i      (state_q == S_DATA),
        .eng_sel_i     (eng_q),
        .rd_data_i     (x_to_mem_rd_data),
        .empty_i       (x_to_mem_empty),
        .almost_full_i (x_data_out_almost_full),
        .rd_en_o       (x_to_mem_rd_en),
        .pop_o         (pop_s),
        .data_o        (x_data_out),
        .valid_o       (x_data_out_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_rise_s) begin
                    if ((dimension == 32'd0) || (numEpochs == 32'd0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CMD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CMD:   state_d = S_DATA;
            S_DATA: begin
                if (last_pop_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DRAIN: begin
                // Second drain cycle is when the final word is on the output.
                if (drain_q) begin
                    if ((epoch_q + 32'd1) == num_epochs_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CMD;
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (!started) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Parameter latch, layout-order counters, epoch bookkeeping and debug counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            started_q     <= 1'b0;
            cmd_addr_q    <= 64'd0;
            epoch_words_q <= 32'd0;
            epoch_bytes_q <= 32'd0;
            num_epochs_q  <= 32'd0;
            epoch_q       <= 32'd0;
            total_q       <= 32'd0;
            eng_q         <= '0;
            wcnt_q        <= '0;
            drain_q       <= 1'b0;
            words_q       <= 16'd0;
        end else begin
            started_q <= started;
            if ((state_q == S_IDLE) && start_rise_s) begin
                cmd_addr_q    <= addr_model;
                epoch_words_q <= epoch_words_s;
                epoch_bytes_q <= {epoch_words_s[25:0], 6'd0};
                num_epochs_q  <= numEpochs;
                epoch_q       <= 32'd0;
                words_q       <= 16'd0;
            end
            if (state_q == S_CMD) begin
                total_q <= 32'd0;
                eng_q   <= '0;
                wcnt_q  <= '0;
                drain_q <= 1'b0;
            end
            if (pop_s) begin
                total_q <= total_q + 32'd1;
                if (wcnt_q == WCNT_W'(WORDS_PER_ENGINE - 1)) begin
                    wcnt_q <= '0;
                    if (eng_q == ENG_W'(ENGINE_NUM - 1)) begin
                        eng_q <= '0;
                    end else begin
                        eng_q <= eng_q + ENG_W'(1);
                    end
                end else begin
                    wcnt_q <= wcnt_q + WCNT_W'(1);
                end
            end
            if (state_q == S_DRAIN) begin
                drain_q <= ~drain_q;
                if (drain_q) begin
                    epoch_q <= epoch_q + 32'd1;
`ifdef SGD_X_EPOCH_HISTORY_EN
                    cmd_addr_q <= cmd_addr_q + {32'd0, epoch_bytes_q};
`endif
                end
            end
            if (x_data_out_valid && (words_q != 16'hFFFF)) begin
                words_q <= words_q + 16'd1;
            end
        end
    end

    assign x_data_send_back_start  = (state_q == S_CMD);
    assign x_data_send_back_addr   = cmd_addr_q;
    assign x_data_send_back_length = epoch_bytes_q;
    assign writeback_done          = (state_q == S_DONE);
    assign state_counters          = {words_q, epoch_q[11:0], state_code(state_q)};

endmodule

// File: doc/sgd_x_fifo_to_dma_wr.md
Name: sgd_x_fifo_to_dma_wr

Overview:
- Downstream drain stage of the x-writeback path, in the DMA clock domain.
- Pops the per-engine 512-bit model-x FIFOs in memory-layout order: per dimension row, engine 0 words 0..3, then engine 1, …, engine N-1.
- Per epoch, issues one DMA write command (start/addr/length), then streams the words to the host-write data port under almost-full backpressure.

Parameters:
- ENGINE_NUM, 8: number of engines / FIFOs.
- WORDS_PER_ENGINE, 4: 512-bit words per engine per row (2048 bits / 512).
- BITS_PER_BANK, 64: features per engine bank per row.
- FEAT_PER_ROW, ENGINE_NUM*BITS_PER_BANK (512): features per row.

Ports:
- clk  in  1: DMA clock.
- rst  in  1: synchronous, active-high reset.
- started  in  1: run enable; rising edge latches parameters.
- addr_model  in  64: host byte base address.
- dimension  in  32: number of features.
- numEpochs  in  32: epochs to write back.
- x_to_mem_rd_data  in  ENGINE_NUM*512: FIFO dout, one 512-bit slice per engine.
- x_to_mem_empty  in  ENGINE_NUM: FIFO empty flags.
- x_to_mem_rd_en  out  ENGINE_NUM: FIFO pop, one-hot or zero.
- x_data_send_back_start  out  1: command pulse.
- x_data_send_back_addr  out  64: command byte address.
- x_data_send_back_length  out  32: command byte length.
- x_data_out  out  512: write data.
- x_data_out_valid  out  1: write data valid.
- x_data_out_almost_full  in  1: downstream backpressure.
- writeback_done  out  1: all epochs streamed.
- state_counters  out  32: debug counters.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0. Reset mid-operation abandons in-flight words. The FIFOs are not reset here.
- Parameter latch: on started 0→1, latch addr_model, dimension and numEpochs.
  - rows = (dimension + FEAT_PER_ROW-1) >> 9.
  - epoch_words = rows*ENGINE_NUM*WORDS_PER_ENGINE.
  - epoch_bytes = epoch_words<<6, 32-bit.
- FSM states: IDLE → CMD → DATA → DRAIN → (CMD | DONE).
- IDLE:
  - On the started rising edge, go to CMD.
  - If dimension==0 or numEpochs==0, go directly to DONE; no command is issued.
- CMD:
  - Single cycle: x_data_send_back_start=1, addr = epoch base (see Optional Feature), length = epoch_bytes.
  - Then go to DATA.
  - start is never high in any other state.
- DATA pop rule: x_to_mem_rd_en[eng] = ~x_to_mem_empty[eng] & ~x_data_out_almost_full. All other rd_en bits are 0.
- DATA counters, on each pop:
  - wcnt++.
  - At wcnt==WORDS_PER_ENGINE-1: wcnt←0 and eng++.
  - At eng==ENGINE_NUM-1: eng←0.
  - total++.
  - When total==epoch_words-1 is popped, go to DRAIN.
- Read latency: the FIFO is standard mode, dout valid 1 cycle after rd_en. The dout is registered into x_data_out, so x_data_out_valid asserts exactly 2 cycles after the corresponding rd_en cycle. Engine select is pipelined to match.
- Backpressure: downstream almost_full must leave ≥3 entries of slack; words already popped are never dropped.
- Empty FIFO at the current engine: stall without skipping. Order is strictly preserved even if other FIFOs are non-empty.
- DRAIN:
  - Wait 2 cycles for the final valid.
  - Then epoch++.
  - If epoch==numEpochs, go to DONE; else go to CMD.
- DONE:
  - writeback_done=1, held until started falls.
  - Then go to IDLE and clear done.
- A started rising edge outside IDLE is ignored.
- state_counters: [31:16] = words streamed (saturating), [15:4] = epochs completed, [3:0] = one-hot state code. The one-hot code is IDLE=1, CMD=2, DATA=4, DRAIN/DONE=8.

Optional Feature:
- Macro: SGD_X_EPOCH_HISTORY_EN.
- Defined: epoch e is written at addr_model + e*epoch_bytes. The address accumulates by adding epoch_bytes in DRAIN. All epochs' models are retained in host memory.
- Undefined: every epoch's command uses addr_model, overwriting the previous model.

Decomposition:
- Shared package sgd_x_wb_pkg holds:
  - the constants ENGINE_NUM, WORDS_PER_ENGINE, BITS_PER_BANK, FEAT_PER_ROW;
  - the one-hot state typedef;
  - a function computing epoch_words from dimension.
- One natural sub-module, sgd_x_wb_rd_pipe: pop-select plus the 2-stage data/valid pipeline with engine-index tracking.

Test Plan:
- dimension=512, numEpochs=1, addr_model=0x1000, FIFOs pre-filled → one start pulse, addr 0x1000, length 2048. 32 valid words in order E0w0..E0w3, E1w0..E7w3. writeback_done=1 after the 2-cycle drain.
- dimension=513 → length 4096, 64 words; the second row starts again at engine 0.
- Assert almost_full for 10 cycles mid-stream → rd_en=0 during those cycles, at most 2 valids after assertion, no loss or duplication, total still 32.
- Keep FIFO 3 empty while FIFOs 4-7 are full → stall after E2w3 with no pop from 4-7. Stream resumes in order when FIFO 3 fills.
- numEpochs=3, dimension=512 → three commands. With SGD_X_EPOCH_HISTORY_EN: addrs 0x1000, 0x1800, 0x2000. Without it: 0x1000 ×3.
- dimension=0 or numEpochs=0 → no command, no rd_en, writeback_done=1. Reset asserted mid-DATA → all outputs 0 the next cycle, FSM in IDLE.
